// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the ALU, writeback and future decode stages.
// Holds the writeback FSM state constants and the memory-op helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair; both halves update together on we.
module hilo_regs
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the combinational MIPS ALU: memory access, HI/LO,
// branch resolution, register-file writeback and exception pulses.
module alu_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       i_datain,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [2:0]        alu_zon,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic [DATA_W-1:0] alu_lo,
  input  logic [DATA_W-1:0] gr2,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              exc_ovf,
  output logic              exc_div0
);

  logic [1:0]        state;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] c_q, hi_in_q, lo_in_q, gr2_q, pc4_q, rdata_q;
  logic [2:0]        zon_q;

  logic [5:0]        opcode, func;
  logic [4:0]        rt, rd, waddr_d;
  logic [15:0]       imm;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_req, hilo_req, br_req, ovf_req, div0_req;
  logic              accept, in_wb;

  assign opcode = instr_q[31:26];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign func   = instr_q[5:0];
  assign imm    = instr_q[15:0];

  assign in_ready = (state == ST_IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // Operands are latched at accept so upstream is free to move on immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      instr_q <= '0;
      c_q     <= '0;
      zon_q   <= '0;
      hi_in_q <= '0;
      lo_in_q <= '0;
      gr2_q   <= '0;
      pc4_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            instr_q <= i_datain;
            c_q     <= alu_c;
            zon_q   <= alu_zon;
            hi_in_q <= alu_hi;
            lo_in_q <= alu_lo;
            gr2_q   <= gr2;
            pc4_q   <= pc_plus4;
            state   <= is_mem_op(i_datain[31:26]) ? ST_MEM : ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= ST_WB;
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = (state == ST_MEM);
  assign mem_we    = (state == ST_MEM) && (opcode == OP_SW);
  assign mem_addr  = c_q;
  assign mem_wdata = gr2_q;

  // Decode of the latched instruction into writeback side effects.
  always_comb begin
    wr_req   = 1'b0;
    hilo_req = 1'b0;
    br_req   = 1'b0;
    ovf_req  = 1'b0;
    div0_req = 1'b0;
    waddr_d  = rt;
    wdata_d  = c_q;
    case (opcode)
      OP_RTYPE: begin
        waddr_d = rd;
        case (func)
          F_ADD, F_SUB: begin
            if (zon_q[1]) ovf_req = 1'b1;
            else          wr_req  = 1'b1;
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
          F_SLL, F_SLLV, F_SRL, F_SRLV, F_SRA, F_SRAV:
            wr_req = 1'b1;
          F_MFHI: begin
            wr_req  = 1'b1;
            wdata_d = hi_q;
          end
          F_MFLO: begin
            wr_req  = 1'b1;
            wdata_d = lo_q;
          end
          F_MULT, F_MULTU: hilo_req = 1'b1;
          F_DIV, F_DIVU: begin
            if (zon_q[1]) div0_req = 1'b1;
            else          hilo_req = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        if (zon_q[1]) ovf_req = 1'b1;
        else          wr_req  = 1'b1;
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: wr_req = 1'b1;
      OP_LW: begin
        wr_req  = 1'b1;
        wdata_d = rdata_q;
      end
      OP_BEQ:  br_req = zon_q[2];
      OP_BNE:  br_req = !zon_q[2];
      default: ;
    endcase
  end

  // A reset edge landing in WB must not leave a pulse visible that cycle.
  assign in_wb = (state == ST_WB) && !reset;

  assign rf_we         = in_wb && wr_req && (waddr_d != 5'd0);
  assign rf_waddr      = REG_AW'(waddr_d);
  assign rf_wdata      = wdata_d;
  assign branch_taken  = in_wb && br_req;
  assign branch_target = pc4_q + {{(DATA_W-18){imm[15]}}, imm, 2'b00};
  assign exc_ovf       = in_wb && ovf_req;
  assign exc_div0      = in_wb && div0_req;

  hilo_regs #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .reset (reset),
    .we    (in_wb && hilo_req),
    .hi_d  (hi_in_q),
    .lo_d  (lo_in_q),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback; every test starts and ends on a
// falling edge, and outputs are sampled on falling edges.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] i_datain, alu_c, alu_hi, alu_lo, gr2, pc_plus4;
  logic [2:0]  alu_zon;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q, branch_target;
  logic        branch_taken, exc_ovf, exc_div0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .i_datain(i_datain), .alu_c(alu_c), .alu_zon(alu_zon), .alu_hi(alu_hi),
    .alu_lo(alu_lo), .gr2(gr2), .pc_plus4(pc_plus4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_q(hi_q), .lo_q(lo_q), .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_ovf(exc_ovf), .exc_div0(exc_div0)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] func);
    return {6'b000000, 5'd1, 5'd2, rd, 5'd0, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  // Presents one instruction for a single accept edge, then scrambles the bus.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] c,
                               input logic [2:0] zon, input logic [31:0] hi,
                               input logic [31:0] lo, input logic [31:0] st,
                               input logic [31:0] pc4);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    i_datain = instr; alu_c = c; alu_zon = zon; alu_hi = hi; alu_lo = lo;
    gr2 = st; pc_plus4 = pc4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    i_datain = $urandom; alu_c = $urandom; alu_zon = 3'($urandom);
    alu_hi = $urandom; alu_lo = $urandom; gr2 = $urandom; pc_plus4 = $urandom;
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b0 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: ready=%b req=%b we=%b expected 0/0/0", in_ready, mem_req, rf_we);
    end
    tests++;
    if (hi_q !== 32'h0 || lo_q !== 32'h0 || branch_target !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_regs: hi=%h lo=%h tgt=%h expected 0", hi_q, lo_q, branch_target);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_add_ovf();
    applyStimulus(rtype(5'd5, 6'b100000), 32'h8000_0000, 3'b011, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (exc_ovf !== 1'b1 || rf_we !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL add_ovf_wb: ovf=%b we=%b ready=%b expected 1/0/0", exc_ovf, rf_we, in_ready);
    end
    @(negedge clk);
    tests++;
    if (exc_ovf !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL add_ovf_after: ovf=%b ready=%b expected 0/1", exc_ovf, in_ready);
    end
    applyStimulus(rtype(5'd6, 6'b100001), 32'h0000_1234, 3'b010, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h1234 || exc_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL addu_wb: we=%b addr=%0d data=%h ovf=%b expected 1/6/1234/0", rf_we, rf_waddr, rf_wdata, exc_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_lw_delay();
    applyStimulus(itype(6'b100011, 5'd8, 16'h0100), 32'h0000_0100, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || rf_we !== 1'b0) begin
        fails++;
        $display("[TB] FAIL lw_mem_%0d: req=%b we=%b addr=%h rfwe=%b expected 1/0/100/0", i, mem_req, mem_we, mem_addr, rf_we);
      end
      if (i == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL lw_wb: we=%b addr=%0d data=%h req=%b expected 1/8/deadbeef/0", rf_we, rf_waddr, rf_wdata, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_mult_mfhi();
    applyStimulus(rtype(5'd0, 6'b011000), 0, 3'b000, 32'h1, 32'h2, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mult_no_rf: rf_we=%b expected 0", rf_we);
    end
    @(negedge clk);
    tests++;
    if (hi_q !== 32'h1 || lo_q !== 32'h2) begin
      fails++;
      $display("[TB] FAIL mult_hilo: hi=%h lo=%h expected 1/2", hi_q, lo_q);
    end
    applyStimulus(rtype(5'd3, 6'b010000), 32'hFFFF_0000, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1) begin
      fails++;
      $display("[TB] FAIL mfhi_wb: we=%b addr=%0d data=%h expected 1/3/1", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    applyStimulus(rtype(5'd4, 6'b010010), 32'hFFFF_0000, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h2) begin
      fails++;
      $display("[TB] FAIL mflo_wb: we=%b addr=%0d data=%h expected 1/4/2", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_div0();
    applyStimulus(rtype(5'd0, 6'b011001), 0, 3'b000, 32'h7, 32'h9, 0, 0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(rtype(5'd0, 6'b011010), 0, 3'b010, 32'hAA, 32'hBB, 0, 0);
    @(negedge clk);
    tests++;
    if (exc_div0 !== 1'b1 || exc_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL div0_pulse: div0=%b ovf=%b expected 1/0", exc_div0, exc_ovf);
    end
    @(negedge clk);
    tests++;
    if (hi_q !== 32'h7 || lo_q !== 32'h9 || exc_div0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL div0_hilo: hi=%h lo=%h div0=%b expected 7/9/0", hi_q, lo_q, exc_div0);
    end
    applyStimulus(rtype(5'd0, 6'b011011), 0, 3'b000, 32'h5, 32'h6, 0, 0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (hi_q !== 32'h5 || lo_q !== 32'h6) begin
      fails++;
      $display("[TB] FAIL divu_hilo: hi=%h lo=%h expected 5/6", hi_q, lo_q);
    end
  endtask

  task automatic test_branch();
    applyStimulus(itype(6'b000100, 5'd2, 16'hFFFF), 0, 3'b100, 0, 0, 0, 32'h40);
    @(negedge clk);
    tests++;
    if (branch_taken !== 1'b1 || branch_target !== 32'h3C || rf_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL beq_taken: taken=%b tgt=%h rfwe=%b expected 1/3c/0", branch_taken, branch_target, rf_we);
    end
    @(negedge clk);
    tests++;
    if (branch_taken !== 1'b0) begin
      fails++;
      $display("[TB] FAIL beq_pulse: taken=%b expected 0", branch_taken);
    end
    applyStimulus(itype(6'b000101, 5'd2, 16'hFFFF), 0, 3'b100, 0, 0, 0, 32'h40);
    @(negedge clk);
    tests++;
    if (branch_taken !== 1'b0 || branch_target !== 32'h3C) begin
      fails++;
      $display("[TB] FAIL bne_not_taken: taken=%b tgt=%h expected 0/3c", branch_taken, branch_target);
    end
    @(negedge clk);
    applyStimulus(itype(6'b000101, 5'd2, 16'h0004), 0, 3'b000, 0, 0, 0, 32'h100);
    @(negedge clk);
    tests++;
    if (branch_taken !== 1'b1 || branch_target !== 32'h110) begin
      fails++;
      $display("[TB] FAIL bne_taken: taken=%b tgt=%h expected 1/110", branch_taken, branch_target);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mem();
    applyStimulus(itype(6'b101011, 5'd9, 16'h0200), 32'h200, 3'b000, 0, 0, 32'h55, 0);
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h55 || mem_addr !== 32'h200) begin
      fails++;
      $display("[TB] FAIL sw_mem: req=%b we=%b wdata=%h addr=%h expected 1/1/55/200", mem_req, mem_we, mem_wdata, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || rf_we !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_mem_ctrl: req=%b rfwe=%b ready=%b expected 0/0/0", mem_req, rf_we, in_ready);
    end
    tests++;
    if (hi_q !== 32'h0 || lo_q !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rst_mem_hilo: hi=%h lo=%h expected 0/0", hi_q, lo_q);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_mem_ready: ready=%b req=%b expected 1/0", in_ready, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_r0();
    applyStimulus(itype(6'b001000, 5'd0, 16'h0007), 32'h7, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b0 || exc_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL addi_r0: we=%b ovf=%b expected 0/0", rf_we, exc_ovf);
    end
    @(negedge clk);
    applyStimulus(itype(6'b001000, 5'd9, 16'h0007), 32'h17, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h17) begin
      fails++;
      $display("[TB] FAIL addi_r9: we=%b addr=%0d data=%h expected 1/9/17", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    i_datain = '0; alu_c = '0; alu_zon = '0; alu_hi = '0; alu_lo = '0;
    gr2 = '0; pc_plus4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_add_ovf();
    test_lw_delay();
    test_mult_mfhi();
    test_div0();
    test_branch();
    test_reset_mem();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the combinational MIPS ALU. Consumes the ALU results `c`, `zon`, `hi` and `lo`, plus the instruction word and store data.
- Performs, in the writeback cycle:
  - lw/sw memory access through a req/ack handshake;
  - owns the architectural HI/LO registers;
  - resolves beq/bne;
  - register-file writeback;
  - overflow and divide-by-zero exception pulses.
- Multi-cycle FSM; one instruction in flight.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  upstream presents an instruction plus its ALU results
in_ready  out  1  stage can accept; high only in IDLE and while reset is low
i_datain  in  32  instruction word (opcode [31:26], rt [20:16], rd [15:11], func [5:0], imm [15:0])
alu_c  in  32  ALU result / memory address
alu_zon  in  3  ALU flags: [2] zero, [1] overflow / div0, [0] negative
alu_hi  in  32  ALU HI result (mult/multu/div/divu)
alu_lo  in  32  ALU LO result
gr2  in  32  rt value, used as store data
pc_plus4  in  32  PC+4 of the instruction
mem_req  out  1  memory request
mem_we  out  1  1 = write (sw), 0 = read (lw)
mem_addr  out  32  byte address
mem_wdata  out  32  store data
mem_ack  in  1  memory done; rdata valid in the same cycle for reads
mem_rdata  in  32  load data
rf_we  out  1  register-file write strobe (1-cycle pulse)
rf_waddr  out  5  destination register
rf_wdata  out  32  write data
hi_q  out  32  architectural HI
lo_q  out  32  architectural LO
branch_taken  out  1  1-cycle pulse
branch_target  out  32  pc_plus4 + (sext(imm) << 2), valid with branch_taken
exc_ovf  out  1  1-cycle pulse: add/sub/addi overflow
exc_div0  out  1  1-cycle pulse: div/divu by zero

Behaviour:
- **Reset values:** all registered outputs, hi_q and lo_q are 0; state is IDLE. Reset in any state (including MEM with mem_req high) forces IDLE on the next edge, drops mem_req, and suppresses any pending write or pulse.
- **Accept:** an instruction is accepted on the edge where in_valid && in_ready. At that edge the stage latches i_datain, alu_c, alu_zon, alu_hi, alu_lo, gr2 and pc_plus4; upstream may change its inputs afterwards.
- **FSM states:** IDLE, MEM, WB.
- **FSM transitions:**
  - IDLE → MEM on accept of lw (opcode 100011) or sw (opcode 101011).
  - IDLE → WB on accept of any other instruction.
  - MEM → WB on the edge where mem_ack = 1.
  - WB → IDLE unconditionally.
- **Latency:** a non-memory instruction accepted at edge N has its outputs in cycle N+1; in_ready is high again in cycle N+2. A memory access takes at least 1 MEM cycle.
- **MEM handshake:**
  - mem_req = 1 throughout MEM.
  - mem_addr = latched alu_c; mem_we = (sw); mem_wdata = latched gr2. All are held stable until ack.
  - mem_ack may be high in the first MEM cycle. For lw, mem_rdata is captured on the ack edge.
  - mem_addr is passed unaligned-unchecked.
- **WB actions (exactly one cycle):**
  - R-type arithmetic/logic/shift/slt (func ∈ add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, sllv, srl, srlv, sra, srav): rf_waddr = rd, rf_wdata = alu_c.
  - I-type addi/addiu/andi/ori/xori/slti/sltiu: rf_waddr = rt, rf_wdata = alu_c.
  - lw: rf_waddr = rt, rf_wdata = captured mem_rdata.
  - mfhi (func 010000) / mflo (func 010010): rf_waddr = rd, rf_wdata = current hi_q / lo_q.
  - mult/multu/div/divu: hi_q ← alu_hi and lo_q ← alu_lo at the end of WB; no rf write.
  - div/divu with zon[1] = 1: HI/LO unchanged; exc_div0 = 1.
  - add/sub/addi with zon[1] = 1: rf_we suppressed; exc_ovf = 1. addu/subu/addiu never trap.
  - beq: branch_taken = zon[2]. bne: branch_taken = !zon[2]. branch_target is always driven in WB.
  - sw: no rf write.
  - Unrecognised opcode/func: no side effects.
- **Register 0:** rf_we is forced 0 when the destination register is 0.
- **Pulse outputs:** rf_we, branch_taken, exc_ovf and exc_div0 are 0 outside WB.
- **HI/LO read-after-write:** an mfhi accepted after a mult sees the new value, because the mult's WB update precedes the mfhi's WB.

Decomposition:
- Shared package mips_pkg: opcode/func localparams and the FSM state enum, reused by the ALU and the future decode stage.
- One sub-module, hilo_regs: HI/LO register pair with write enable and synchronous reset.

Test Plan:
- **add overflow:** add with alu_c = 0x8000_0000, zon = 3'b011, rd = 5 → exc_ovf pulse in cycle N+1, rf_we = 0, in_ready back in cycle N+2.
- **lw with delayed ack:** lw with alu_c = 0x100, rt = 8; mem_ack asserted after 3 cycles with rdata = 0xDEAD_BEEF → mem_req high for 3 cycles with addr 0x100 and we = 0; then rf_we = 1, rf_waddr = 8, rf_wdata = 0xDEAD_BEEF.
- **mult then mfhi/mflo:** mult with alu_hi = 0x1, alu_lo = 0x2, followed by mfhi rd = 3 and mflo rd = 4 → hi_q = 1, lo_q = 2; rf writes r3 = 1 then r4 = 2.
- **div by zero:** div with zon[1] = 1 and previous HI/LO = 7/9 → exc_div0 pulse; HI/LO stay 7/9.
- **Branches:** beq with zon[2] = 1, pc_plus4 = 0x40, imm = 0xFFFF → branch_taken = 1, target = 0x3C. bne with the same inputs → branch_taken = 0.
- **Reset mid-MEM:** reset asserted for one cycle while in MEM on an sw → mem_req = 0 on the next cycle, no rf write, hi_q = lo_q = 0, in_ready = 1 once reset drops. Also: addi to rt = 0 → rf_we stays 0.
